// File: rtl/kmap_scanner.sv
// rtl/kmap_scanner.sv - exhaustive 4-input stimulus/response scanner with truth-table check
//
// Purpose:
//   Drives all 16 input vectors {a,b,c,d} of a combinational block.
//   Vectors are visited in binary-reflected Gray order or in binary order.
//   Each vector is held for SETTLE cycles, and `out` is sampled on the last
//   cycle of the hold. The sampled responses build a 16-bit truth table.
//   The scanner counts minterms and compares the table with a golden value
//   that was latched at start.
//
// Parameters:
//   SETTLE      cycles each vector is held before sampling (1..255)
//   GRAY_ORDER  1 = Gray order (k ^ (k>>1)), 0 = binary order k
//
// Ports:
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   start          one-cycle scan request, honoured only in IDLE
//   expected       golden truth table, captured when start is accepted
//   out            response of the combinational block under test
//   a,b,c,d        applied vector, a = bit 3 (MSB), d = bit 0 (LSB)
//   busy           high while scanning
//   done           one-cycle pulse when the scan completes
//   truth_table    captured responses, bit index = {a,b,c,d}
//   minterm_count  number of vectors for which out = 1 (0..16)
//   pass           truth_table == latched expected
//                  valid from done until the next accepted start

module kmap_scanner #(
    parameter int unsigned SETTLE     = 1,
    parameter bit          GRAY_ORDER = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] expected,
    input  logic        out,
    output logic        a,
    output logic        b,
    output logic        c,
    output logic        d,
    output logic        busy,
    output logic        done,
    output logic [15:0] truth_table,
    output logic [4:0]  minterm_count,
    output logic        pass
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(SETTLE - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  step;
    logic [7:0]  hold;
    logic [3:0]  vec;
    logic [15:0] exp_q;
    logic [15:0] tbl;
    logic [15:0] tbl_sampled;
    logic [4:0]  cnt;
    logic        pass_q;
    logic        sample;

    // Maps a scan step index to the vector applied at that step.
    function automatic logic [3:0] vec_of(input logic [3:0] k);
        if (GRAY_ORDER)
            return k ^ (k >> 1);
        else
            return k;
    endfunction

    // Sampling happens on the last cycle of the hold window.
    assign sample = (state == S_SCAN) && (hold == HOLD_LAST);

    // The table as it looks once the current response is written.
    // The pass comparison uses this value so that it includes the final bit.
    always_comb begin
        tbl_sampled      = tbl;
        tbl_sampled[vec] = out;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_SCAN;
            S_SCAN:  if (sample && (step == 4'd15)) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            step   <= 4'd0;
            hold   <= 8'd0;
            vec    <= 4'd0;
            exp_q  <= 16'd0;
            tbl    <= 16'd0;
            cnt    <= 5'd0;
            pass_q <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        tbl    <= 16'd0;
                        cnt    <= 5'd0;
                        pass_q <= 1'b0;
                        exp_q  <= expected;
                        step   <= 4'd0;
                        hold   <= 8'd0;
                        vec    <= vec_of(4'd0);
                    end
                end
                S_SCAN: begin
                    if (sample) begin
                        tbl <= tbl_sampled;
                        cnt <= cnt + {4'd0, out};
                        if (step == 4'd15) begin
                            pass_q <= (tbl_sampled == exp_q);
                        end else begin
                            step <= step + 4'd1;
                            vec  <= vec_of(step + 4'd1);
                            hold <= 8'd0;
                        end
                    end else begin
                        hold <= hold + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign {a, b, c, d}  = vec;
    assign busy          = (state == S_SCAN);
    assign done          = (state == S_DONE);
    assign truth_table   = tbl;
    assign minterm_count = cnt;
    assign pass          = pass_q;

endmodule

// File: tb/tb_kmap_scanner.sv
// tb/tb_kmap_scanner.sv - directed self-checking bench for kmap_scanner
module tb_kmap_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] expected = 16'd0;
    int          mode = 0;   // 0: xor, 1: and, 2: (a&b)|(c&d)

    // g: SETTLE=1 Gray, s: SETTLE=3 Gray, n: SETTLE=1 binary
    logic [3:0]  v_g, v_s, v_n;
    logic        o_g, o_s, o_n;
    logic        busy_g, busy_s, busy_n;
    logic        done_g, done_s, done_n;
    logic [15:0] tbl_g, tbl_s, tbl_n;
    logic [4:0]  cnt_g, cnt_s, cnt_n;
    logic        pass_g, pass_s, pass_n;

    int passed = 0;
    int total  = 0;

    logic [3:0] gray_seq [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                  4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

    function automatic logic dut_fn(input int m, input logic [3:0] v);
        case (m)
            0:       return ^v;
            1:       return &v;
            default: return (v[3] & v[2]) | (v[1] & v[0]);
        endcase
    endfunction

    assign o_g = dut_fn(mode, v_g);
    assign o_s = dut_fn(mode, v_s);
    assign o_n = dut_fn(mode, v_n);

    always #5 clk = ~clk;

    kmap_scanner #(.SETTLE(1), .GRAY_ORDER(1'b1)) u_g (
        .clk(clk), .reset(reset), .start(start), .expected(expected), .out(o_g),
        .a(v_g[3]), .b(v_g[2]), .c(v_g[1]), .d(v_g[0]),
        .busy(busy_g), .done(done_g), .truth_table(tbl_g),
        .minterm_count(cnt_g), .pass(pass_g));

    kmap_scanner #(.SETTLE(3), .GRAY_ORDER(1'b1)) u_s (
        .clk(clk), .reset(reset), .start(start), .expected(expected), .out(o_s),
        .a(v_s[3]), .b(v_s[2]), .c(v_s[1]), .d(v_s[0]),
        .busy(busy_s), .done(done_s), .truth_table(tbl_s),
        .minterm_count(cnt_s), .pass(pass_s));

    kmap_scanner #(.SETTLE(1), .GRAY_ORDER(1'b0)) u_n (
        .clk(clk), .reset(reset), .start(start), .expected(expected), .out(o_n),
        .a(v_n[3]), .b(v_n[2]), .c(v_n[1]), .d(v_n[0]),
        .busy(busy_n), .done(done_n), .truth_table(tbl_n),
        .minterm_count(cnt_n), .pass(pass_n));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        start = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Start edge becomes edge 0; returns 1 ns after it.
    task automatic start_pulse(input logic [15:0] exp_val);
        expected = exp_val;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if ({v_g, busy_g, done_g} !== 6'd0) $display("FAIL reset_vec_flags got=%b exp=000000", {v_g, busy_g, done_g}); else passed++;
        total++; if (tbl_g !== 16'd0) $display("FAIL reset_table got=%h exp=0000", tbl_g); else passed++;
        total++; if ({cnt_g, pass_g} !== 6'd0) $display("FAIL reset_count_pass got=%b exp=000000", {cnt_g, pass_g}); else passed++;
    endtask

    task automatic test_xor_gray();
        apply_reset();
        mode = 0;
        start_pulse(16'h6996);
        for (int n = 0; n < 16; n++) begin
            total++; if (v_g !== gray_seq[n]) $display("FAIL gray_seq[%0d] got=%0d exp=%0d", n, v_g, gray_seq[n]); else passed++;
            total++; if (v_n !== 4'(n)) $display("FAIL binary_seq[%0d] got=%0d exp=%0d", n, v_n, n); else passed++;
            total++; if ({busy_g, done_g} !== 2'b10) $display("FAIL xor_busy[%0d] got=%b exp=10", n, {busy_g, done_g}); else passed++;
            tick();
        end
        total++; if ({busy_g, done_g} !== 2'b01) $display("FAIL xor_done_time got=%b exp=01", {busy_g, done_g}); else passed++;
        total++; if (tbl_g !== 16'h6996) $display("FAIL xor_table got=%h exp=6996", tbl_g); else passed++;
        total++; if (cnt_g !== 5'd8) $display("FAIL xor_count got=%0d exp=8", cnt_g); else passed++;
        total++; if (pass_g !== 1'b1) $display("FAIL xor_pass got=%b exp=1", pass_g); else passed++;
        total++; if ({done_n, tbl_n, pass_n} !== {1'b1, 16'h6996, 1'b1}) $display("FAIL binary_result got=%b/%h/%b exp=1/6996/1", done_n, tbl_n, pass_n); else passed++;
        tick();
        total++; if ({busy_g, done_g} !== 2'b00) $display("FAIL xor_done_pulse got=%b exp=00", {busy_g, done_g}); else passed++;
        total++; if ({v_g, tbl_g, cnt_g, pass_g} !== {4'd8, 16'h6996, 5'd8, 1'b1}) $display("FAIL xor_hold got=%h/%h/%0d/%b exp=8/6996/8/1", v_g, tbl_g, cnt_g, pass_g); else passed++;
    endtask

    task automatic test_and_settle3();
        apply_reset();
        mode = 1;
        start_pulse(16'h8000);
        for (int n = 0; n <= 48; n++) begin
            total++; if (v_s !== gray_seq[(n / 3 > 15) ? 15 : n / 3]) $display("FAIL settle3_vec[%0d] got=%0d exp=%0d", n, v_s, gray_seq[(n / 3 > 15) ? 15 : n / 3]); else passed++;
            total++; if (done_s !== (n == 48)) $display("FAIL settle3_done[%0d] got=%b exp=%b", n, done_s, n == 48); else passed++;
            if (n < 48) tick();
        end
        total++; if (tbl_s !== 16'h8000) $display("FAIL and_table got=%h exp=8000", tbl_s); else passed++;
        total++; if (cnt_s !== 5'd1) $display("FAIL and_count got=%0d exp=1", cnt_s); else passed++;
        total++; if (pass_s !== 1'b1) $display("FAIL and_pass got=%b exp=1", pass_s); else passed++;
    endtask

    task automatic test_mismatch();
        apply_reset();
        mode = 2;
        start_pulse(16'hF88F);
        for (int n = 1; n <= 16; n++) tick();
        total++; if (done_g !== 1'b1) $display("FAIL mismatch_done got=%b exp=1", done_g); else passed++;
        total++; if (tbl_g !== 16'hF888) $display("FAIL mismatch_table got=%h exp=f888", tbl_g); else passed++;
        total++; if (cnt_g !== 5'd7) $display("FAIL mismatch_count got=%0d exp=7", cnt_g); else passed++;
        total++; if (pass_g !== 1'b0) $display("FAIL mismatch_pass got=%b exp=0", pass_g); else passed++;
        total++; if ({tbl_n, pass_n} !== {16'hF888, 1'b0}) $display("FAIL mismatch_binary got=%h/%b exp=f888/0", tbl_n, pass_n); else passed++;
    endtask

    task automatic test_mid_scan();
        int dones;
        apply_reset();
        mode = 0;
        start_pulse(16'h6996);
        dones = 0;
        for (int n = 1; n <= 20; n++) begin
            if (n == 5) begin
                start = 1'b1;
                expected = 16'h0000;
            end
            tick();
            start = 1'b0;
            if (done_g) begin
                dones++;
                total++; if (n != 16) $display("FAIL restart_done_time got=%0d exp=16", n); else passed++;
            end
        end
        total++; if (dones != 1) $display("FAIL restart_single_done got=%0d exp=1", dones); else passed++;
        total++; if (pass_g !== 1'b1) $display("FAIL restart_expected_kept got=%b exp=1", pass_g); else passed++;

        start_pulse(16'h6996);
        for (int n = 1; n <= 9; n++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        total++; if ({busy_g, done_g, v_g} !== 6'd0) $display("FAIL midreset_flags got=%b exp=000000", {busy_g, done_g, v_g}); else passed++;
        total++; if ({tbl_g, cnt_g} !== 21'd0) $display("FAIL midreset_table got=%h/%0d exp=0000/0", tbl_g, cnt_g); else passed++;
        dones = 0;
        for (int n = 0; n < 10; n++) begin
            tick();
            if (done_g) dones++;
        end
        total++; if (dones != 0) $display("FAIL midreset_no_done got=%0d exp=0", dones); else passed++;

        reset = 1'b1;
        start = 1'b1;
        tick();
        reset = 1'b0;
        start = 1'b0;
        total++; if (busy_g !== 1'b0) $display("FAIL reset_beats_start got=%b exp=0", busy_g); else passed++;

        start_pulse(16'h6996);
        for (int n = 1; n <= 16; n++) tick();
        total++; if ({done_g, tbl_g, pass_g} !== {1'b1, 16'h6996, 1'b1}) $display("FAIL after_reset_scan got=%b/%h/%b exp=1/6996/1", done_g, tbl_g, pass_g); else passed++;
    endtask

    task automatic test_back_to_back();
        apply_reset();
        mode = 0;
        expected = 16'h6996;
        start = 1'b1;
        tick();
        for (int n = 1; n <= 16; n++) tick();
        total++; if ({done_g, tbl_g} !== {1'b1, 16'h6996}) $display("FAIL b2b_first got=%b/%h exp=1/6996", done_g, tbl_g); else passed++;
        tick();
        total++; if ({busy_g, done_g, tbl_g} !== {2'b00, 16'h6996}) $display("FAIL b2b_idle got=%b/%h exp=00/6996", {busy_g, done_g}, tbl_g); else passed++;
        tick();
        total++; if ({busy_g, tbl_g, cnt_g, pass_g, v_g} !== {1'b1, 16'h0000, 5'd0, 1'b0, 4'd0}) $display("FAIL b2b_restart got=%b/%h/%0d/%b/%0d exp=1/0000/0/0/0", busy_g, tbl_g, cnt_g, pass_g, v_g); else passed++;
        for (int n = 1; n <= 16; n++) tick();
        start = 1'b0;
        total++; if ({done_g, tbl_g, cnt_g, pass_g} !== {1'b1, 16'h6996, 5'd8, 1'b1}) $display("FAIL b2b_second got=%b/%h/%0d/%b exp=1/6996/8/1", done_g, tbl_g, cnt_g, pass_g); else passed++;
    endtask

    initial begin
        test_reset();
        test_xor_gray();
        test_and_settle3();
        test_mismatch();
        test_mid_scan();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
